// File: rtl/decoder_pkg.sv
// Shared types and helpers for the sequenced 2-to-4 decoder.
package decoder_pkg;

    localparam int unsigned CODE_W = 2;
    localparam int unsigned Y_W    = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PASS  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_SCAN  = 2'd3
    } state_e;

    // Binary code to one-hot, bit k set iff code == k.
    function automatic logic [Y_W-1:0] onehot4(input logic [CODE_W-1:0] code);
        return Y_W'(4'b0001 << code);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small code FIFO; also exposes post-edge head/flags so the parent can register its outputs.
import decoder_pkg::*;

module sync_fifo #(
    parameter int unsigned DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [CODE_W-1:0] wdata,
    input  logic              pop,
    output logic              full,
    output logic              empty,
    output logic              full_nxt_c,
    output logic              empty_nxt_c,
    output logic [CODE_W-1:0] head_nxt_c
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    logic [CODE_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [AW-1:0]     rd_ptr_nxt;
    logic [CW-1:0]     count_q;
    logic [CW-1:0]     count_nxt;

    // Occupancy and head as they will be after this edge.
    always_comb begin
        count_nxt   = count_q + CW'(push) - CW'(pop);
        rd_ptr_nxt  = rd_ptr_q + AW'(pop);
        full_nxt_c  = (count_nxt == CW'(DEPTH));
        empty_nxt_c = (count_nxt == CW'(0));
        head_nxt_c  = '0;
        if (count_nxt != CW'(0)) begin
            // A lone surviving entry can only be the one being written now.
            if ((count_q == CW'(0)) || ((count_q == CW'(1)) && pop)) begin
                head_nxt_c = wdata;
            end else begin
                head_nxt_c = mem_q[rd_ptr_nxt];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= wdata;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            rd_ptr_q <= rd_ptr_nxt;
            count_q  <= count_nxt;
            full     <= full_nxt_c;
            empty    <= empty_nxt_c;
        end
    end

endmodule

// File: rtl/decoder_2x4_seq.sv
// 2-to-4 decoder with buffered pass-through mode and a self-generated walking one-hot scan mode.
import decoder_pkg::*;

module decoder_2x4_seq #(
    parameter int unsigned DEPTH   = 2,
    parameter int unsigned DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               scan,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [CODE_W-1:0]  a,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [Y_W-1:0]     y,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               busy
);

    state_e             state_q;
    state_e             state_nxt;
    logic [CODE_W-1:0]  code_q;
    logic [CODE_W-1:0]  code_nxt;
    logic [DWELL_W-1:0] dwell_cnt_q;
    logic [DWELL_W-1:0] dwell_cnt_nxt;
    logic [DWELL_W-1:0] dwell_lat_q;
    logic [DWELL_W-1:0] dwell_lat_nxt;
    logic               in_ready_nxt;
    logic               out_valid_nxt;
    logic [Y_W-1:0]     y_nxt;
    logic               busy_nxt;

    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_full_nxt;
    logic               fifo_empty_nxt;
    logic [CODE_W-1:0]  fifo_head_nxt;
    logic               push;
    logic               pop;
    logic               out_hs;
    logic               fifo_mode;

    assign fifo_mode = (state_q == ST_PASS) || (state_q == ST_DRAIN);
    assign out_hs    = out_valid && out_ready;
    assign push      = in_valid && in_ready && !fifo_full;
    assign pop       = out_hs && fifo_mode && !fifo_empty;

    sync_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (push),
        .wdata       (a),
        .pop         (pop),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .full_nxt_c  (fifo_full_nxt),
        .empty_nxt_c (fifo_empty_nxt),
        .head_nxt_c  (fifo_head_nxt)
    );

    // Next state, scan counters and next registered outputs.
    always_comb begin
        state_nxt     = state_q;
        code_nxt      = code_q;
        dwell_cnt_nxt = dwell_cnt_q;
        dwell_lat_nxt = dwell_lat_q;
        in_ready_nxt  = 1'b0;
        out_valid_nxt = 1'b0;
        y_nxt         = '0;
        busy_nxt      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (scan) begin
                    state_nxt = ST_SCAN;
                end else if (en) begin
                    state_nxt = ST_PASS;
                end
            end
            ST_PASS: begin
                if (scan || !en) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (fifo_empty) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (!scan && out_hs) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        if ((state_q != ST_SCAN) && (state_nxt == ST_SCAN)) begin
            code_nxt      = '0;
            dwell_cnt_nxt = '0;
            dwell_lat_nxt = dwell;
        end else if ((state_q == ST_SCAN) && out_hs) begin
            // Each code is repeated dwell+1 times before advancing.
            if (dwell_cnt_q == dwell_lat_q) begin
                dwell_cnt_nxt = '0;
                code_nxt      = code_q + CODE_W'(1);
            end else begin
                dwell_cnt_nxt = dwell_cnt_q + DWELL_W'(1);
            end
        end

        in_ready_nxt = (state_nxt == ST_PASS) && !fifo_full_nxt;
        busy_nxt     = (state_nxt != ST_IDLE);
        case (state_nxt)
            ST_PASS, ST_DRAIN: begin
                out_valid_nxt = !fifo_empty_nxt;
                y_nxt         = fifo_empty_nxt ? '0 : onehot4(fifo_head_nxt);
            end
            ST_SCAN: begin
                out_valid_nxt = 1'b1;
                y_nxt         = onehot4(code_nxt);
            end
            default: begin
                out_valid_nxt = 1'b0;
                y_nxt         = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            code_q      <= '0;
            dwell_cnt_q <= '0;
            dwell_lat_q <= '0;
            in_ready    <= 1'b0;
            out_valid   <= 1'b0;
            y           <= '0;
            busy        <= 1'b0;
        end else begin
            state_q     <= state_nxt;
            code_q      <= code_nxt;
            dwell_cnt_q <= dwell_cnt_nxt;
            dwell_lat_q <= dwell_lat_nxt;
            in_ready    <= in_ready_nxt;
            out_valid   <= out_valid_nxt;
            y           <= y_nxt;
            busy        <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_decoder_2x4_seq.sv
// Directed bench for decoder_2x4_seq: reset, decode, backpressure, mode switch, scan wrap, reset mid-scan.
module tb_decoder_2x4_seq;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       scan;
    logic [3:0] dwell;
    logic [1:0] a;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] y;
    logic       out_valid;
    logic       out_ready;
    logic       busy;

    int checks;
    int failures;

    decoder_2x4_seq #(.DEPTH(2), .DWELL_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .scan      (scan),
        .dwell     (dwell),
        .a         (a),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; in_valid = 1'b1; a = 2'd0;
        tick();
        tick();
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset in_ready: got %b expected 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset out_valid: got %b expected 0", out_valid); end
        checks++; if (y !== 4'b0000) begin failures++; $display("FAIL reset y: got %b expected 0000", y); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset busy: got %b expected 0", busy); end
        in_valid = 1'b0; en = 1'b0; rst_n = 1'b1;
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle busy: got %b expected 0", busy); end
    endtask

    task automatic test_decode();
        logic [3:0] exp_y [4];
        exp_y[0] = 4'b0001; exp_y[1] = 4'b0010; exp_y[2] = 4'b0100; exp_y[3] = 4'b1000;
        en = 1'b1; out_ready = 1'b1;
        tick();
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL decode pass in_ready: got %b expected 1", in_ready); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL decode pass busy: got %b expected 1", busy); end
        for (int k = 0; k < 4; k++) begin
            a = 2'(k); in_valid = 1'b1;
            tick();
            checks++; if (out_valid !== 1'b1 || y !== exp_y[k]) begin failures++; $display("FAIL decode y[%0d]: got v=%b y=%b expected v=1 y=%b", k, out_valid, y, exp_y[k]); end
            checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL decode in_ready[%0d]: got %b expected 1", k, in_ready); end
        end
        in_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0 || y !== 4'b0000) begin failures++; $display("FAIL decode empty: got v=%b y=%b expected v=0 y=0000", out_valid, y); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        a = 2'd2; in_valid = 1'b1;
        tick();
        checks++; if (y !== 4'b0100 || in_ready !== 1'b1) begin failures++; $display("FAIL bp first: got y=%b rdy=%b expected y=0100 rdy=1", y, in_ready); end
        a = 2'd3;
        tick();
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp full in_ready: got %b expected 0", in_ready); end
        checks++; if (y !== 4'b0100) begin failures++; $display("FAIL bp full y: got %b expected 0100", y); end
        in_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b1 || y !== 4'b0100) begin failures++; $display("FAIL bp hold: got v=%b y=%b expected v=1 y=0100", out_valid, y); end
        out_ready = 1'b1;
        tick();
        checks++; if (y !== 4'b1000 || in_ready !== 1'b1) begin failures++; $display("FAIL bp release: got y=%b rdy=%b expected y=1000 rdy=1", y, in_ready); end
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp drained: got %b expected 0", out_valid); end
    endtask

    task automatic test_mode_switch();
        out_ready = 1'b0;
        a = 2'd1; in_valid = 1'b1;
        tick();
        a = 2'd3;
        tick();
        in_valid = 1'b0;
        checks++; if (y !== 4'b0010) begin failures++; $display("FAIL mode head: got %b expected 0010", y); end
        scan = 1'b1; dwell = 4'd0; out_ready = 1'b1;
        tick();
        checks++; if (y !== 4'b1000 || busy !== 1'b1) begin failures++; $display("FAIL mode drain2: got y=%b busy=%b expected y=1000 busy=1", y, busy); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL mode drain in_ready: got %b expected 0", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL mode drain empty: got v=%b busy=%b expected v=0 busy=1", out_valid, busy); end
        tick();
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL mode idle gap: got v=%b busy=%b expected v=0 busy=0", out_valid, busy); end
        tick();
        checks++; if (out_valid !== 1'b1 || y !== 4'b0001 || busy !== 1'b1) begin failures++; $display("FAIL mode scan start: got v=%b y=%b busy=%b expected v=1 y=0001 busy=1", out_valid, y, busy); end
        scan = 1'b0; en = 1'b0;
        tick();
        checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || y !== 4'b0000) begin failures++; $display("FAIL scan exit: got busy=%b v=%b y=%b expected 0 0 0000", busy, out_valid, y); end
    endtask

    task automatic test_scan_wrap();
        logic [3:0] seq [9];
        seq[0] = 4'b0001; seq[1] = 4'b0001; seq[2] = 4'b0010; seq[3] = 4'b0010;
        seq[4] = 4'b0100; seq[5] = 4'b0100; seq[6] = 4'b1000; seq[7] = 4'b1000;
        seq[8] = 4'b0001;
        dwell = 4'd1; out_ready = 1'b0; scan = 1'b1;
        tick();
        checks++; if (in_ready !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL scan entry: got rdy=%b busy=%b expected rdy=0 busy=1", in_ready, busy); end
        dwell = 4'd3;
        tick();
        checks++; if (out_valid !== 1'b1 || y !== 4'b0001) begin failures++; $display("FAIL scan stall: got v=%b y=%b expected v=1 y=0001", out_valid, y); end
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            checks++; if (out_valid !== 1'b1 || y !== seq[i]) begin failures++; $display("FAIL scan seq[%0d]: got v=%b y=%b expected v=1 y=%b", i, out_valid, y, seq[i]); end
            tick();
        end
    endtask

    task automatic test_reset_mid_scan();
        for (int i = 0; i < 8 && y !== 4'b0100; i++) tick();
        out_ready = 1'b0;
        checks++; if (y !== 4'b0100) begin failures++; $display("FAIL midscan reach 0100: got %b expected 0100", y); end
        tick();
        checks++; if (y !== 4'b0100 || out_valid !== 1'b1) begin failures++; $display("FAIL midscan hold: got v=%b y=%b expected v=1 y=0100", out_valid, y); end
        rst_n = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0 || y !== 4'b0000 || busy !== 1'b0) begin failures++; $display("FAIL midscan reset: got v=%b y=%b busy=%b expected 0 0000 0", out_valid, y, busy); end
        rst_n = 1'b1; scan = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL post reset idle: got v=%b busy=%b expected 0 0", out_valid, busy); end
    endtask

    initial begin
        checks = 0; failures = 0;
        rst_n = 1'b0; en = 1'b0; scan = 1'b0; dwell = 4'd0;
        a = 2'd0; in_valid = 1'b0; out_ready = 1'b0;
        test_reset();
        test_decode();
        test_backpressure();
        test_mode_switch();
        test_scan_wrap();
        test_reset_mid_scan();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/decoder_2x4_seq.md
DECODER_2X4_SEQ -- requirements
Module: decoder_2x4_seq

Interface
REQ-001 Parameter DEPTH, default 2, code FIFO depth in entries (power of 2, >=2).
REQ-002 Parameter DWELL_W, default 4, width of the DWELL input.
REQ-003 CLK  input  1  sole clock, all state updates on rising edge.
REQ-004 RST_N  input  1  reset, synchronous, active-low.
REQ-005 EN  input  1  pass-through enable: decode incoming codes.
REQ-006 SCAN  input  1  scan-mode request: self-generate walking one-hot pattern.
REQ-007 DWELL  input  DWELL_W  scan repeat count minus one per code, sampled on SCAN entry.
REQ-008 A  input  2  binary code in, valid with IN_VALID.
REQ-009 IN_VALID  input  1  A valid.
REQ-010 IN_READY  output  1  block accepts A this cycle.
REQ-011 Y  output  4  one-hot decoded output, Y[k]=1 iff code==k.
REQ-012 OUT_VALID  output  1  Y valid.
REQ-013 OUT_READY  input  1  sink accepts Y this cycle.
REQ-014 BUSY  output  1  high whenever FSM is not IDLE.

Function
REQ-015 The FSM SHALL have states IDLE, PASS, DRAIN, SCAN.
REQ-016 IDLE: SCAN=1 -> SCAN (priority); else EN=1 -> PASS; else stay.
REQ-017 PASS: SCAN=1 or EN=0 -> DRAIN; else stay.
REQ-018 DRAIN: FIFO empty -> IDLE; else stay, irrespective of EN/SCAN.
REQ-019 SCAN: SCAN=0 and a handshake (OUT_VALID && OUT_READY) this cycle -> IDLE; else stay.
REQ-020 Input handshake: IN_READY = (state==PASS) && FIFO not full; push on IN_VALID && IN_READY; no full-bypass.
REQ-021 In PASS/DRAIN, OUT_VALID = FIFO not empty and Y = one-hot of FIFO head; pop on OUT_VALID && OUT_READY.
REQ-022 Latency: code accepted at edge N SHALL drive OUT_VALID/Y from edge N+1 if FIFO was empty (registered, no combinational A->Y path).
REQ-023 Simultaneous push and pop SHALL both take effect; occupancy unchanged.
REQ-024 Y SHALL be 4'b0000 whenever OUT_VALID=0.
REQ-025 While OUT_VALID=1 and OUT_READY=0, Y SHALL hold stable and OUT_VALID SHALL not drop (all states).
REQ-026 On SCAN entry: code counter=0, dwell counter=0, DWELL latched; OUT_VALID=1 from the first SCAN cycle.
REQ-027 In SCAN, each handshake increments dwell counter; when dwell counter equals latched DWELL, it clears and code increments modulo 4 (3 -> 0).
REQ-028 Order across modes SHALL be preserved: all FIFO codes emitted before any scan code.
REQ-029 IN_READY SHALL be 0 in IDLE, DRAIN and SCAN.

Reset
REQ-030 With RST_N=0 at a rising edge: state=IDLE, FIFO pointers/count=0, code/dwell counters=0, latched DWELL=0.
REQ-031 Outputs during/after reset until new activity: IN_READY=0, OUT_VALID=0, Y=0, BUSY=0.
REQ-032 Reset mid-operation SHALL discard buffered codes and abort scan without completing pending handshakes.

Structure
REQ-033 Package decoder_pkg SHALL hold the FSM state enum and a 2-to-4 one-hot decode function.
REQ-034 FIFO SHALL be sub-module sync_fifo (parameter DEPTH, width 2, full/empty flags, same CLK/RST_N).

Verification
REQ-035 Reset: RST_N=0 two cycles with EN=1, IN_VALID=1 -> IN_READY=0, OUT_VALID=0, Y=0000, BUSY=0.
REQ-036 Decode: EN=1, OUT_READY=1, send A=0,1,2,3 -> Y=0001,0010,0100,1000, each one cycle after acceptance.
REQ-037 Backpressure: OUT_READY=0, send A=2,3 -> IN_READY=0 after 2 accepts (DEPTH=2), Y=0100 held; release -> 0100 then 1000.
REQ-038 Scan wrap: SCAN=1, DWELL=1, OUT_READY=1 -> Y sequence 0001,0001,0010,0010,0100,0100,1000,1000,0001.
REQ-039 Mode switch: FIFO holds 1,3, raise SCAN -> DRAIN emits 0010,1000, then IDLE one cycle, then scan starts at 0001.
REQ-040 Reset mid-scan: RST_N=0 while Y=0100, OUT_READY=0 -> next cycle OUT_VALID=0, Y=0000, BUSY=0.
